synaptic_current_gen: RTL and testbench

Converts presynaptic spike events into a Q16.16 synaptic current for an `izhikevich_neuron` `current` input. It is the receiving end of the neuron spike interface: upstream neurons' `spike` outputs enter here, and the result drives the downstream neuron's current. Each input has a programmable signed weight. The current decays exponentially, is saturated, and updates once per enabled simulation step.

---
 rtl/synaptic_current_gen.sv | 105 ++++++++++
 tb/tb_synaptic_current_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/synaptic_current_gen.sv
// Synaptic current generator: turns presynaptic spike edges into a weighted,
// exponentially decaying, saturated Q16.16 current for a neuron model.
module synaptic_current_gen #(
  parameter int                 N_IN      = 4,
  parameter int                 AW        = 2,
  parameter int                 TAU_SHIFT = 4,
  parameter logic signed [31:0] I_MAX     = 32'sd6553600
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_IN-1:0]     spike_in,
  input  logic                en,
  input  logic                w_we,
  input  logic [AW-1:0]       w_addr,
  input  logic signed [31:0]  w_data,
  output logic signed [31:0]  current,
  output logic [15:0]         event_count
);

  localparam logic signed [39:0] I_MAX_X = 40'(I_MAX);
  localparam logic signed [39:0] I_MIN_X = -40'(I_MAX);

  logic [N_IN-1:0]    spike_prev_q, spike_prev_d;
  logic [N_IN-1:0]    pending_q, pending_d;
  logic signed [31:0] current_q, current_d;
  logic [15:0]        event_count_q, event_count_d;
  logic signed [31:0] weight_q [N_IN];
  logic signed [31:0] weight_d [N_IN];

  logic [N_IN-1:0]    edge_det;
  logic [N_IN-1:0]    hits;
  logic signed [39:0] cur_x;
  logic signed [39:0] decayed;
  logic signed [39:0] wsum;
  logic signed [39:0] sum;
  logic [4:0]         pop;
  logic [16:0]        cnt_sum;

  always_comb begin
    edge_det = spike_in & ~spike_prev_q;
    hits     = pending_q | edge_det;

    // Weighted sum uses the registered weights, so a same-cycle write is
    // only seen from the following update onward.
    wsum = '0;
    pop  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (hits[i]) begin
        wsum = wsum + 40'(weight_q[i]);
        pop  = pop + 5'd1;
      end
    end

    cur_x   = 40'(current_q);
    decayed = cur_x - (cur_x >>> TAU_SHIFT);
    sum     = decayed + wsum;
    cnt_sum = {1'b0, event_count_q} + 17'(pop);

    spike_prev_d  = spike_in;
    pending_d     = pending_q;
    current_d     = current_q;
    event_count_d = event_count_q;

    if (en) begin
      pending_d = '0;
      if (sum > I_MAX_X)      current_d = I_MAX;
      else if (sum < I_MIN_X) current_d = -I_MAX;
      else                    current_d = sum[31:0];
      event_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end else begin
      pending_d = hits;
    end

    for (int i = 0; i < N_IN; i++) begin
      weight_d[i] = weight_q[i];
    end
    if (w_we && (int'(w_addr) < N_IN)) begin
      weight_d[w_addr] = w_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_prev_q  <= '0;
      pending_q     <= '0;
      current_q     <= '0;
      event_count_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      spike_prev_q  <= spike_prev_d;
      pending_q     <= pending_d;
      current_q     <= current_d;
      event_count_q <= event_count_d;
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= weight_d[i];
      end
    end
  end

  assign current     = current_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_synaptic_current_gen.sv
// Directed bench for synaptic_current_gen with hand-computed expected values.
module tb_synaptic_current_gen;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [3:0]         spike_in;
  logic               en;
  logic               w_we;
  logic [1:0]         w_addr;
  logic signed [31:0] w_data;
  logic signed [31:0] current;
  logic [15:0]        event_count;

  int n_total = 0;
  int n_pass  = 0;

  synaptic_current_gen #(
    .N_IN(4), .AW(2), .TAU_SHIFT(4), .I_MAX(32'sd6553600)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .en(en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .current(current), .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cur(input string tag, input logic signed [31:0] exp);
    n_total++;
    assert (current === exp) n_pass++;
    else $error("FAIL %s current got %0d want %0d", tag, current, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    n_total++;
    assert (event_count === exp) n_pass++;
    else $error("FAIL %s event_count got %0d want %0d", tag, event_count, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic signed [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    step();
    w_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; spike_in = '0; en = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    #3;
    chk_cur("reset", 0);
    chk_cnt("reset", 0);
    reset_n = 1'b1;
    step();

    // single pulse and decay
    wr(2'd0, 32'sd65536);
    spike_in = 4'b0001; en = 1'b1; step();
    chk_cur("pulse", 65536);
    chk_cnt("pulse", 1);
    spike_in = 4'b0000; step();
    chk_cur("decay1", 61440);
    step();
    chk_cur("decay2", 57600);
    chk_cnt("decay2", 1);

    // level held high counts once
    en = 1'b0;
    do_reset();
    wr(2'd0, 32'sd65536);
    spike_in = 4'b0001; en = 1'b1; step();
    chk_cur("hold1", 65536);
    for (int k = 0; k < 9; k++) step();
    chk_cur("hold10", 36664);
    chk_cnt("hold10", 1);
    spike_in = 4'b0000; en = 1'b0;

    // saturation both ways
    do_reset();
    for (int a = 0; a < 4; a++) wr(2'(a), 32'sd4000000);
    spike_in = 4'b1111; en = 1'b1; step();
    chk_cur("clamp_pos", 32'sd6553600);
    chk_cnt("clamp_pos", 4);
    spike_in = 4'b0000; en = 1'b0; step();
    for (int a = 0; a < 4; a++) wr(2'(a), -32'sd4000000);
    chk_cur("hold_en0", 32'sd6553600);
    spike_in = 4'b1111; en = 1'b1; step();
    chk_cur("clamp_neg", -32'sd6553600);
    chk_cnt("clamp_neg", 8);
    spike_in = 4'b0000; step();
    chk_cur("neg_decay", -32'sd6144000);

    // pending while disabled, collapsed to one event
    en = 1'b0;
    do_reset();
    wr(2'd1, 32'sd65536);
    spike_in = 4'b0010; step();
    spike_in = 4'b0000; step();
    spike_in = 4'b0010; step();
    spike_in = 4'b0000; step();
    chk_cur("pend_hold", 0);
    chk_cnt("pend_hold", 0);
    en = 1'b1; step();
    chk_cur("pend_apply", 65536);
    chk_cnt("pend_apply", 1);
    step();
    chk_cur("pend_clear", 61440);
    chk_cnt("pend_clear", 1);

    // write/spike collision uses the old weight
    spike_in = 4'b0100; w_we = 1'b1; w_addr = 2'd2; w_data = 32'sd131072;
    step();
    w_we = 1'b0;
    chk_cur("collide", 57600);
    chk_cnt("collide", 2);
    spike_in = 4'b0000; step();
    chk_cur("collide_dec", 54000);
    spike_in = 4'b0100; step();
    chk_cur("new_w", 181697);
    chk_cnt("new_w", 3);
    spike_in = 4'b0000;

    // async reset mid-decay, spike held across release
    #2;
    reset_n = 1'b0; spike_in = 4'b0010;
    #1;
    chk_cur("async_rst", 0);
    chk_cnt("async_rst", 0);
    #2;
    reset_n = 1'b1;
    step();
    chk_cnt("held_release", 1);
    chk_cur("held_release", 0);
    spike_in = 4'b0000; step();
    spike_in = 4'b0001; step();
    chk_cur("zero_w", 0);
    chk_cnt("zero_w", 2);
    spike_in = 4'b0000; en = 1'b0;
    wr(2'd0, 32'sd65536);
    spike_in = 4'b0001; en = 1'b1; step();
    chk_cur("rewrite", 65536);
    spike_in = 4'b0000; en = 1'b0;

    // small negative values creep to zero
    do_reset();
    wr(2'd3, -32'sd5);
    spike_in = 4'b1000; en = 1'b1; step();
    chk_cur("small_neg", -5);
    spike_in = 4'b0000; step();
    chk_cur("small_neg_dec", -4);
    for (int k = 0; k < 4; k++) step();
    chk_cur("small_neg_zero", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout current got %0d want finish", current);
    $fatal(1, "timeout");
  end

endmodule
